// File: rtl/mem_host_loader.sv
// Host-side loader: streams a program into IMEM, runs the CPU for a fixed
// number of cycles, then reads a DMEM window out on a valid/ready stream.
module mem_host_loader #(
   parameter int DATA_W      = 32,
   parameter int LEN_W       = 10,
   parameter int ADDR_STRIDE = 4
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              start,
   input  logic [LEN_W-1:0]  prog_len,
   input  logic [31:0]       run_cycles,
   input  logic [31:0]       dump_base,
   input  logic [LEN_W-1:0]  dump_len,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              cpu_enable,
   output logic [31:0]       imem_addr,
   output logic              imem_wen,
   output logic              imem_ren,
   output logic [DATA_W-1:0] imem_wdata,
   output logic [31:0]       dmem_addr,
   output logic              dmem_wen,
   output logic              dmem_ren,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DREQ, DOUT, FINISH} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  prog_len_q, prog_len_d;
   logic [LEN_W-1:0]  dump_len_q, dump_len_d;
   logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
   logic [LEN_W-1:0]  dump_cnt_q, dump_cnt_d;
   logic [31:0]       run_cnt_q, run_cnt_d;
   logic [31:0]       dump_addr_q, dump_addr_d;
   logic [31:0]       dreq_base;
   logic              first_q, first_d;
   logic              s_ready_q, s_ready_d;
   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              cpu_enable_q, cpu_enable_d;
   logic [31:0]       imem_addr_q, imem_addr_d;
   logic              imem_wen_q, imem_wen_d;
   logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
   logic [31:0]       dmem_addr_q, dmem_addr_d;
   logic              dmem_ren_q, dmem_ren_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Zero-length phases are skipped rather than entered for a dead cycle.
   function automatic state_t after_run(input logic [LEN_W-1:0] dlen);
      return (dlen != '0) ? DREQ : FINISH;
   endfunction

   function automatic state_t after_load(input logic [31:0] rc, input logic [LEN_W-1:0] dlen);
      return (rc != '0) ? RUN : after_run(dlen);
   endfunction

   always_comb begin
      state_d      = state_q;
      prog_len_d   = prog_len_q;
      dump_len_d   = dump_len_q;
      word_cnt_d   = word_cnt_q;
      dump_cnt_d   = dump_cnt_q;
      run_cnt_d    = run_cnt_q;
      dump_addr_d  = dump_addr_q;
      dreq_base    = dump_addr_q;
      first_d      = first_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      cpu_enable_d = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wen_d   = 1'b0;
      imem_wdata_d = imem_wdata_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_ren_d   = 1'b0;
      done_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               prog_len_d  = prog_len;
               dump_len_d  = dump_len;
               run_cnt_d   = run_cycles;
               dump_addr_d = dump_base;
               dreq_base   = dump_base;
               word_cnt_d  = '0;
               dump_cnt_d  = '0;
               state_d     = (prog_len != '0) ? LOAD : after_load(run_cycles, dump_len);
            end
         end
         LOAD: begin
            if (s_valid && s_ready_q) begin
               imem_wen_d   = 1'b1;
               imem_addr_d  = 32'(word_cnt_q) * 32'(ADDR_STRIDE);
               imem_wdata_d = s_data;
               word_cnt_d   = word_cnt_q + 1'b1;
               if (word_cnt_q == prog_len_q - 1'b1) begin
                  state_d = after_load(run_cnt_q, dump_len_q);
               end
            end
         end
         RUN: begin
            // Entered with cpu_enable low, so the last IMEM write lands first.
            if (run_cnt_q != '0) begin
               cpu_enable_d = 1'b1;
               run_cnt_d    = run_cnt_q - 1'b1;
            end else begin
               state_d = after_run(dump_len_q);
            end
         end
         DREQ: begin
            state_d = DOUT;
            first_d = 1'b1;
         end
         DOUT: begin
            if (first_q) begin
               first_d   = 1'b0;
               m_valid_d = 1'b1;
               m_data_d  = dmem_rdata;
            end else if (m_valid_q && m_ready) begin
               m_valid_d  = 1'b0;
               dump_cnt_d = dump_cnt_q + 1'b1;
               state_d    = (dump_cnt_q == dump_len_q - 1'b1) ? FINISH : DREQ;
            end
         end
         FINISH: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // The read strobe is registered on entry so it is high during the DREQ cycle.
      if (state_d == DREQ) begin
         dmem_ren_d  = 1'b1;
         dmem_addr_d = dreq_base;
         dump_addr_d = dreq_base + 32'(ADDR_STRIDE);
      end

      s_ready_d = (state_d == LOAD);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q      <= IDLE;
         prog_len_q   <= '0;
         dump_len_q   <= '0;
         word_cnt_q   <= '0;
         dump_cnt_q   <= '0;
         run_cnt_q    <= '0;
         dump_addr_q  <= '0;
         first_q      <= 1'b0;
         s_ready_q    <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         cpu_enable_q <= 1'b0;
         imem_addr_q  <= '0;
         imem_wen_q   <= 1'b0;
         imem_wdata_q <= '0;
         dmem_addr_q  <= '0;
         dmem_ren_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         prog_len_q   <= prog_len_d;
         dump_len_q   <= dump_len_d;
         word_cnt_q   <= word_cnt_d;
         dump_cnt_q   <= dump_cnt_d;
         run_cnt_q    <= run_cnt_d;
         dump_addr_q  <= dump_addr_d;
         first_q      <= first_d;
         s_ready_q    <= s_ready_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         cpu_enable_q <= cpu_enable_d;
         imem_addr_q  <= imem_addr_d;
         imem_wen_q   <= imem_wen_d;
         imem_wdata_q <= imem_wdata_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_ren_q   <= dmem_ren_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign cpu_enable = cpu_enable_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wen   = imem_wen_q;
   assign imem_ren   = 1'b0;
   assign imem_wdata = imem_wdata_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wen   = 1'b0;
   assign dmem_ren   = dmem_ren_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_mem_host_loader.sv
// Bench for mem_host_loader: queue-based model of IMEM writes, DMEM reads and
// dump words, checked every cycle, plus literal expectations per scenario.
module tb_mem_host_loader;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  prog_len = '0;
   logic [31:0] run_cycles = '0;
   logic [31:0] dump_base = '0;
   logic [9:0]  dump_len = '0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready = 1'b0;
   logic        cpu_enable;
   logic [31:0] imem_addr;
   logic        imem_wen;
   logic        imem_ren;
   logic [31:0] imem_wdata;
   logic [31:0] dmem_addr;
   logic        dmem_wen;
   logic        dmem_ren;
   logic [31:0] dmem_rdata = '0;
   logic        busy;
   logic        done;

   mem_host_loader dut (
      .clk(clk), .arst(arst), .start(start), .prog_len(prog_len),
      .run_cycles(run_cycles), .dump_base(dump_base), .dump_len(dump_len),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .cpu_enable(cpu_enable), .imem_addr(imem_addr), .imem_wen(imem_wen),
      .imem_ren(imem_ren), .imem_wdata(imem_wdata), .dmem_addr(dmem_addr),
      .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_rdata(dmem_rdata),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Model state
   logic [63:0] exp_imem[$];
   logic [31:0] exp_daddr[$];
   logic [31:0] exp_mdata[$];
   logic [31:0] prog_words[16];
   int cur_run, en_cnt, done_cnt, busy_cyc, n_wen, n_ren, n_hs, stall_seen;
   int first_wen_cyc, last_wen_cyc, first_en_cyc;
   int mr_low = 0;
   logic [31:0] wen_addr_log[16], wen_data_log[16], ren_log[16], hs_log[16];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hD000_0000 | {24'b0, a[9:2]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // DMEM: data only valid the cycle after a read strobe, garbage otherwise.
   always @(posedge clk)
      dmem_rdata <= dmem_ren ? mem_word(dmem_addr) : (32'hBAD0_0000 ^ 32'(cyc));

   // Sink: holds m_ready low for mr_low sampled cycles of each word.
   initial begin : sink
      int stall;
      stall = 0;
      forever begin
         @(negedge clk);
         if (m_valid && stall < mr_low) begin
            m_ready = 1'b0;
            stall++;
         end else if (m_valid) begin
            m_ready = 1'b1;
            stall = 0;
         end else begin
            m_ready = 1'b0;
         end
      end
   end

   // Compare process: every cycle, between clock edges.
   initial begin : cmp
      logic        prev_mv, prev_mr;
      logic [31:0] prev_md;
      logic [63:0] e;
      prev_mv = 1'b0; prev_mr = 1'b0; prev_md = '0;
      forever begin
         @(negedge clk); #1;
         cyc++;
         if (arst) begin
            prev_mv = 1'b0;
            prev_mr = 1'b0;
         end else begin
            chk("const_zero_enables", {imem_ren, dmem_wen}, 0);
            if (busy) busy_cyc++;
            if (imem_wen) begin
               chk("wen_without_cpu", cpu_enable, 0);
               if (exp_imem.size() == 0) begin
                  chk("imem_extra_write", 1, 0);
               end else begin
                  e = exp_imem.pop_front();
                  chk("imem_addr", imem_addr, e[63:32]);
                  chk("imem_wdata", imem_wdata, e[31:0]);
                  if (exp_imem.size() == 0) chk("s_ready_drop", s_ready, 0);
               end
               if (n_wen == 0) first_wen_cyc = cyc;
               last_wen_cyc = cyc;
               if (n_wen < 16) begin
                  wen_addr_log[n_wen] = imem_addr;
                  wen_data_log[n_wen] = imem_wdata;
               end
               n_wen++;
            end
            if (cpu_enable) begin
               en_cnt++;
               if (en_cnt == 1) begin
                  first_en_cyc = cyc;
                  chk("en_after_load", exp_imem.size(), 0);
               end
            end
            if (dmem_ren) begin
               chk("run_done_before_dump", en_cnt, cur_run);
               if (exp_daddr.size() == 0) chk("dmem_extra_read", 1, 0);
               else chk("dmem_addr", dmem_addr, exp_daddr.pop_front());
               if (n_ren < 16) ren_log[n_ren] = dmem_addr;
               n_ren++;
            end
            if (prev_mv && !prev_mr) begin
               chk("m_hold", {m_valid, m_data}, {1'b1, prev_md});
               stall_seen++;
            end
            if (m_valid && m_ready) begin
               if (exp_mdata.size() == 0) chk("m_extra_word", 1, 0);
               else chk("m_data", m_data, exp_mdata.pop_front());
               if (n_hs < 16) hs_log[n_hs] = m_data;
               n_hs++;
            end
            if (done) begin
               done_cnt++;
               chk("done_not_busy", busy, 0);
            end
            prev_mv = m_valid;
            prev_mr = m_ready;
            prev_md = m_data;
         end
      end
   end

   task automatic feed(input int plen, input bit gap);
      int i, n, guard;
      bit acc;
      i = 0; n = 0; guard = 0; acc = 0;
      while (i < plen && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (acc) i++;
         if (i < plen) begin
            s_valid = !(gap && n[0]);
            s_data  = prog_words[i];
            n++;
         end else begin
            s_valid = 1'b0;
         end
         acc = s_valid && s_ready;
      end
      s_valid = 1'b0;
      if (guard >= 2000) chk("feed_timeout", 1, 0);
   endtask

   task automatic start_job(input int plen, input logic [31:0] rc, input logic [31:0] base,
                            input int dlen, input int mrl, input bit gap, input bit poke);
      logic [31:0] a;
      exp_imem.delete(); exp_daddr.delete(); exp_mdata.delete();
      for (int i = 0; i < plen; i++) exp_imem.push_back({32'(i * 4), prog_words[i]});
      for (int k = 0; k < dlen; k++) begin
         a = base + 32'(k * 4);
         exp_daddr.push_back(a);
         exp_mdata.push_back(mem_word(a));
      end
      cur_run = int'(rc); en_cnt = 0; done_cnt = 0; busy_cyc = 0;
      n_wen = 0; n_ren = 0; n_hs = 0; stall_seen = 0;
      first_wen_cyc = 0; last_wen_cyc = 0; first_en_cyc = 0;
      mr_low = mrl;
      @(negedge clk);
      start = 1'b1; prog_len = 10'(plen); run_cycles = rc; dump_base = base; dump_len = 10'(dlen);
      @(negedge clk);
      // Disturb the inputs to show they were latched.
      start = 1'b0; prog_len = 10'd7; run_cycles = 32'd99; dump_base = 32'h0; dump_len = 10'd5;
      fork
         feed(plen, gap);
         if (poke) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
   endtask

   task automatic finish_job();
      int t;
      t = 0;
      while (done_cnt == 0 && t < 3000) begin
         @(negedge clk); #2;
         t++;
      end
      @(negedge clk); #2;
      chk("done_count", done_cnt, 1);
      chk("run_cycles", en_cnt, cur_run);
      chk("model_drained", exp_imem.size() + exp_daddr.size() + exp_mdata.size(), 0);
      chk("idle_after_done", {busy, cpu_enable, s_ready, m_valid}, 0);
   endtask

   initial begin : main
      int t;
      for (int i = 0; i < 16; i++) prog_words[i] = 32'h1234_0000 + 32'(i * 17);
      repeat (3) @(negedge clk);
      #2;
      chk("reset_outputs", {s_ready, m_valid, m_data, cpu_enable, imem_wen, imem_addr[7:0],
                            dmem_ren, dmem_addr[7:0], busy, done}, 0);
      arst = 1'b0;
      $display("reset released, outputs idle");

      // Load A,B,C back-to-back then run 5 cycles, one dump word.
      prog_words[0] = 32'hAAAA_000A; prog_words[1] = 32'hBBBB_000B; prog_words[2] = 32'hCCCC_000C;
      start_job(3, 32'd5, 32'h100, 1, 0, 1'b0, 1'b0);
      finish_job();
      chk("t1_wen_count", n_wen, 3);
      chk("t1_wen_back_to_back", last_wen_cyc - first_wen_cyc, 2);
      chk("t1_addrs", {wen_addr_log[0][7:0], wen_addr_log[1][7:0], wen_addr_log[2][7:0]}, 24'h000408);
      chk("t1_data_c", wen_data_log[2], 32'hCCCC_000C);
      chk("t1_data_a", wen_data_log[0], 32'hAAAA_000A);
      chk("t1_en_count", en_cnt, 5);
      chk("t1_en_after_wen", first_en_cyc > last_wen_cyc, 1);
      $display("load/run job: wen=%0d en=%0d dump=%0d", n_wen, en_cnt, n_hs);
      for (int i = 0; i < 16; i++) prog_words[i] = 32'h1234_0000 + 32'(i * 17);

      // Dump with 3 cycles of backpressure per word.
      start_job(1, 32'd2, 32'h40, 2, 3, 1'b0, 1'b0);
      finish_job();
      chk("t2_ren0", ren_log[0], 32'h40);
      chk("t2_ren1", ren_log[1], 32'h44);
      chk("t2_word0", hs_log[0], 32'hD000_0010);
      chk("t2_word1", hs_log[1], 32'hD000_0011);
      chk("t2_stalls", stall_seen, 6);
      $display("backpressure job: reads=%0d words=%0d stalls=%0d", n_ren, n_hs, stall_seen);

      // All lengths zero: straight to FINISH.
      start_job(0, 32'd0, 32'h80, 0, 0, 1'b0, 1'b0);
      finish_job();
      chk("t3_no_enables", {32'(n_wen), 32'(n_ren + en_cnt)}, 0);
      chk("t3_busy_one_cycle", busy_cyc, 1);
      $display("zero-length job: busy_cycles=%0d done=%0d", busy_cyc, done_cnt);

      // Reset in the middle of RUN.
      start_job(2, 32'd40, 32'h0, 1, 0, 1'b0, 1'b0);
      t = 0;
      while (en_cnt < 5 && t < 200) begin
         @(negedge clk); #2;
         t++;
      end
      chk("t4_reached_run", en_cnt >= 5, 1);
      #1 arst = 1'b1;
      #1;
      chk("t4_abort", {cpu_enable, busy, s_ready, m_valid, dmem_ren, imem_wen}, 0);
      exp_imem.delete(); exp_daddr.delete(); exp_mdata.delete();
      @(negedge clk);
      arst = 1'b0;
      $display("reset mid-run: cpu_enable=%0b busy=%0b", cpu_enable, busy);

      // Restart after reset; start poked during LOAD; dump address wraps.
      start_job(4, 32'd3, 32'hFFFF_FFFC, 2, 1, 1'b1, 1'b1);
      finish_job();
      chk("t5_wen_count", n_wen, 4);
      chk("t5_last_addr", wen_addr_log[3], 32'hC);
      chk("t5_wrap_addr", ren_log[1], 32'h0);
      chk("t5_word0", hs_log[0], 32'hD000_00FF);
      $display("ignored-start job: wen=%0d en=%0d reads=%0d", n_wen, en_cnt, n_ren);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
